// File: rtl/openhw_regfile_pkg.sv
// ============================================================================
// openhw_regfile_pkg
// Shared types and sizing helpers for the multi-port integer register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package openhw_regfile_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  function automatic int numregs(input int e_supported);
    return (e_supported != 0) ? 16 : 32;
  endfunction

endpackage

`default_nettype wire

// File: rtl/openhw_regfile_clr_seq.sv
// ============================================================================
// openhw_regfile_clr_seq
// INIT/RUN sequencer that sweeps x1..x(NUMREGS-1) to zero after reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module openhw_regfile_clr_seq
  import openhw_regfile_pkg::*;
#(
  parameter int NUMREGS = 32,
  parameter int AW      = $clog2(NUMREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          rdy
);

  localparam logic [AW-1:0] c_LAST = AW'(NUMREGS - 1);

  rf_state_t     r_state;
  logic [AW-1:0] r_idx;
  logic          r_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RF_INIT;
      r_idx   <= AW'(1);
      r_rdy   <= 1'b0;
    end else begin
      case (r_state)
        RF_INIT: begin
          if (r_idx == c_LAST) begin
            r_state <= RF_RUN;
            r_rdy   <= 1'b1;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        RF_RUN: begin
          r_rdy <= 1'b1;
        end
        default: begin
          r_state <= RF_INIT;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  // No clearing while reset is held, so the index stays parked at x1.
  assign clr_en   = (r_state == RF_INIT) && reset_n;
  assign clr_addr = r_idx;
  assign rdy      = r_rdy;

endmodule

`default_nettype wire

// File: rtl/openhw_regfile_mp.sv
// ============================================================================
// openhw_regfile_mp
// Multi-port integer register file with clear sweep and optional bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module openhw_regfile_mp
  import openhw_regfile_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int E_SUPPORTED = 0,
  parameter int NRD         = 2,
  parameter int NWR         = 1,
  parameter int BYPASS      = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NWR-1:0]             we,
  input  logic [NWR*REG_ADDR_W-1:0]  wa,
  input  logic [NWR*XLEN-1:0]        wd,
  input  logic [NRD*REG_ADDR_W-1:0]  ra,
  output logic [NRD*XLEN-1:0]        rd,
  output logic                       rdy
);

  localparam int NUMREGS = numregs(E_SUPPORTED);
  localparam int AW      = $clog2(NUMREGS);
  localparam logic [REG_ADDR_W:0] c_NUMREGS = (REG_ADDR_W + 1)'(NUMREGS);

  logic          w_clr_en;
  logic [AW-1:0] w_clr_addr;
  logic          w_rdy;

  openhw_regfile_clr_seq #(
    .NUMREGS (NUMREGS),
    .AW      (AW)
  ) u_clr_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_en   (w_clr_en),
    .clr_addr (w_clr_addr),
    .rdy      (w_rdy)
  );

  assign rdy = w_rdy;

  logic [XLEN-1:0]       r_regs    [1:NUMREGS-1];
  logic [NWR-1:0]        w_wvalid;
  logic [REG_ADDR_W-1:0] w_wa_full [NWR];
  logic [AW-1:0]         w_waddr   [NWR];
  logic [XLEN-1:0]       w_wdata   [NWR];

  for (genvar p = 0; p < NWR; p++) begin : g_wr
    assign w_wa_full[p] = wa[p*REG_ADDR_W +: REG_ADDR_W];
    assign w_waddr[p]   = w_wa_full[p][AW-1:0];
    assign w_wdata[p]   = wd[p*XLEN +: XLEN];
    // Writes in the reset cycle are dropped even though the FSM is still in RUN.
    assign w_wvalid[p]  = reset_n && w_rdy && we[p] &&
                          (w_wa_full[p] != '0) &&
                          ({1'b0, w_wa_full[p]} < c_NUMREGS);
  end

  // Sweep owns the single storage write port; later functional ports win conflicts.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_regs[w_clr_addr] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wvalid[p]) begin
          r_regs[w_waddr[p]] <= w_wdata[p];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [REG_ADDR_W-1:0] w_ra;
    logic                  w_rvalid;
    logic                  w_hit;
    logic [XLEN-1:0]       w_byp;

    assign w_ra     = ra[i*REG_ADDR_W +: REG_ADDR_W];
    assign w_rvalid = w_rdy && (w_ra != '0) && ({1'b0, w_ra} < c_NUMREGS);

    always_comb begin
      w_hit = 1'b0;
      w_byp = '0;
      for (int p = 0; p < NWR; p++) begin
        if (w_wvalid[p] && (w_wa_full[p] == w_ra)) begin
          w_hit = 1'b1;
          w_byp = w_wdata[p];
        end
      end
    end

    assign rd[i*XLEN +: XLEN] = !w_rvalid                ? '0    :
                                ((BYPASS != 0) && w_hit) ? w_byp :
                                r_regs[w_ra[AW-1:0]];
  end

endmodule

`default_nettype wire

// File: tb/tb_openhw_regfile_mp.sv
// ============================================================================
// tb_openhw_regfile_mp
// Two register file configurations against a behavioural register model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_openhw_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Config A: 32 regs, 2 read / 2 write ports, bypass on
  logic [1:0]   we_a;
  logic [9:0]   wa_a, ra_a;
  logic [127:0] wd_a, rd_a;
  logic         rdy_a;

  // Config B: E mode, 1 read / 1 write port, read-old
  logic [0:0]   we_b;
  logic [4:0]   wa_b, ra_b;
  logic [31:0]  wd_b, rd_b;
  logic         rdy_b;

  openhw_regfile_mp #(
    .XLEN(64), .E_SUPPORTED(0), .NRD(2), .NWR(2), .BYPASS(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .we(we_a), .wa(wa_a), .wd(wd_a),
    .ra(ra_a), .rd(rd_a), .rdy(rdy_a)
  );

  openhw_regfile_mp #(
    .XLEN(32), .E_SUPPORTED(1), .NRD(1), .NWR(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .we(we_b), .wa(wa_b), .wd(wd_b),
    .ra(ra_b), .rd(rd_b), .rdy(rdy_b)
  );

  int vec  = 0;
  int errs = 0;

  logic [63:0] mem_a [32];
  logic [31:0] mem_b [32];
  bit          run_a, run_b;
  int          cnt_a, cnt_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_a(input logic [4:0] a);
    logic [63:0] v;
    if (!run_a || a == 5'd0) return 64'd0;
    v = mem_a[a];
    if (reset_n)
      for (int p = 0; p < 2; p++)
        if (we_a[p] && wa_a[p*5 +: 5] == a) v = wd_a[p*64 +: 64];
    return v;
  endfunction

  function automatic logic [63:0] exp_b(input logic [4:0] a);
    if (!run_b || a == 5'd0 || a >= 5'd16) return 64'd0;
    return {32'd0, mem_b[a]};
  endfunction

  task automatic check_all();
    #1;
    check("rdy_a", {63'd0, rdy_a}, {63'd0, run_a});
    check("rdy_b", {63'd0, rdy_b}, {63'd0, run_b});
    for (int i = 0; i < 2; i++)
      check($sformatf("rd_a%0d", i), rd_a[i*64 +: 64], exp_a(ra_a[i*5 +: 5]));
    check("rd_b", {32'd0, rd_b}, exp_b(ra_b));
  endtask

  // Register-level effect of one rising edge.
  task automatic model_edge();
    if (!reset_n) begin
      run_a = 0; cnt_a = 0;
    end else if (!run_a) begin
      cnt_a++; mem_a[cnt_a] = 64'd0;
      if (cnt_a == 31) run_a = 1;
    end else begin
      for (int p = 0; p < 2; p++)
        if (we_a[p] && wa_a[p*5 +: 5] != 5'd0) mem_a[wa_a[p*5 +: 5]] = wd_a[p*64 +: 64];
    end
    if (!reset_n) begin
      run_b = 0; cnt_b = 0;
    end else if (!run_b) begin
      cnt_b++; mem_b[cnt_b] = 32'd0;
      if (cnt_b == 15) run_b = 1;
    end else if (we_b[0] && wa_b != 5'd0 && wa_b < 5'd16) begin
      mem_b[wa_b] = wd_b;
    end
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_in();
    we_a = 2'($urandom);
    wa_a = 10'($urandom);
    wd_a = {$urandom, $urandom, $urandom, $urandom};
    ra_a[4:0] = ($urandom_range(0, 2) == 0) ? wa_a[4:0] : 5'($urandom);
    ra_a[9:5] = ($urandom_range(0, 2) == 0) ? wa_a[9:5] : 5'($urandom);
    we_b = 1'($urandom);
    wa_b = 5'($urandom);
    wd_b = $urandom;
    ra_b = ($urandom_range(0, 2) == 0) ? wa_b : 5'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    we_a = '0; wa_a = '0; wd_a = '0; ra_a = '0;
    we_b = '0; wa_b = '0; wd_b = '0; ra_b = '0;
    run_a = 0; run_b = 0; cnt_a = 0; cnt_b = 0;
    for (int r = 0; r < 32; r++) begin mem_a[r] = 64'd0; mem_b[r] = 32'd0; end
    repeat (2) @(posedge clk);
    #1;
    rand_in();
    tick();
    tick();

    // Initial sweep with a write attempt during INIT
    reset_n = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      rand_in();
      we_b = 1'b0;
      if (c == 3) begin
        we_a = 2'b01; wa_a[4:0] = 5'd9; wd_a[63:0] = 64'h77;
        we_b = 1'b1;  wa_b = 5'd9;      wd_b = 32'h77;
      end
      tick();
    end
    we_a = '0; we_b = '0;
    ra_a = {5'd9, 5'd9}; ra_b = 5'd9;
    #1;
    check("rdy_up", {63'd0, rdy_a}, 64'd1);
    check("x9_a", rd_a[63:0], 64'd0);
    check("x9_b", {32'd0, rd_b}, 64'd0);
    for (int r = 0; r < 32; r++) begin
      ra_a = {5'(31 - r), 5'(r)}; ra_b = 5'(r);
      tick();
    end

    // Same-cycle write conflict: port 1 wins
    we_a = 2'b11; wa_a = {5'd5, 5'd5}; wd_a = {64'h5555, 64'hAAAA}; ra_a = {5'd5, 5'd5};
    #1;
    check("conf_byp", rd_a[63:0], 64'h5555);
    tick();
    we_a = 2'b00;
    #1;
    check("conflict", rd_a[63:0], 64'h5555);
    tick();

    // Bypass vs read-old
    we_a = 2'b01; wa_a[4:0] = 5'd7; wd_a[63:0] = 64'h1234; ra_a[4:0] = 5'd7;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h1111;
    #1;
    check("byp_a", rd_a[63:0], 64'h1234);
    tick();
    we_a = 2'b00;
    wd_b = 32'h1234; ra_b = 5'd7;
    #1;
    check("old_b", {32'd0, rd_b}, 64'h1111);
    tick();
    we_b = 1'b0;
    #1;
    check("new_b", {32'd0, rd_b}, 64'h1234);
    tick();

    // x0 writes ignored, out-of-range E-mode writes dropped
    we_a = 2'b11; wa_a = 10'd0; wd_a = {128{1'b1}};
    we_b = 1'b1;  wa_b = 5'd4;  wd_b = 32'h44;
    tick();
    we_a = 2'b00; ra_a = 10'd0;
    wa_b = 5'd20; wd_b = 32'h1; ra_b = 5'd20;
    #1;
    check("x0_p0", rd_a[63:0], 64'd0);
    check("x0_p1", rd_a[127:64], 64'd0);
    tick();
    we_b = 1'b0;
    #1;
    check("x20_b", {32'd0, rd_b}, 64'd0);
    ra_b = 5'd4;
    #1;
    check("x4_b", {32'd0, rd_b}, 64'h44);
    tick();

    repeat (300) begin
      rand_in();
      tick();
    end

    // One-cycle reset mid-RUN
    we_a = 2'b01; wa_a[4:0] = 5'd3; wd_a[63:0] = 64'hDEAD; we_b = 1'b0;
    tick();
    we_a = 2'b00; reset_n = 1'b0; ra_a = {5'd3, 5'd3};
    tick();
    reset_n = 1'b1;
    #1;
    check("rdy_drop", {63'd0, rdy_a}, 64'd0);
    for (int c = 0; c < 31; c++) begin
      rand_in();
      ra_a = {5'd3, 5'd3};
      tick();
    end
    we_a = 2'b00; we_b = 1'b0;
    #1;
    check("x3_clr", rd_a[63:0], 64'd0);
    tick();

    // Multi-cycle reset then full sweep
    reset_n = 1'b0;
    repeat (3) begin rand_in(); tick(); end
    reset_n = 1'b1;
    repeat (40) begin rand_in(); tick(); end

    repeat (100) begin
      rand_in();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/openhw_regfile_mp.md
# openhw_regfile_mp

Parametrised multi-port integer register file for the IEU: configurable read and write port counts, E-mode sizing, optional write-to-read bypass and a sequential clear sweep that replaces per-flop reset. It sits between decode (read addresses) and writeback (write ports) and reports readiness to the hazard unit while the clear sweep runs.

## Interface
- XLEN, 64: data width.
- E_SUPPORTED, 0: 1 = 16 architectural registers, else 32.
- NRD, 2: read ports, 1..4.
- NWR, 1: write ports, 1..2.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads.
- One clock; reset is synchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- we  in  NWR  per-port write enable.
- wa  in  NWR×5  per-port write address.
- wd  in  NWR×XLEN  per-port write data.
- ra  in  NRD×5  per-port read address.
- rd  out  NRD×XLEN  per-port read data.
- rdy  out  1  high when clear sweep complete and writes accepted.

## Operation
- NUMREGS = E_SUPPORTED ? 16 : 32; storage holds x1..x(NUMREGS-1); x0 not stored.
- States: INIT, RUN.
- reset_n low on a rising edge: state <= INIT, sweep index <= 1, rdy <= 0. Register contents are not reset.
- INIT: each cycle writes 0 to register[index], index++; when index == NUMREGS-1 is cleared, next state RUN, rdy <= 1. All we ignored in INIT; all rd return 0.
- RUN: for each port p with we[p]=1, wa[p]!=0, wa[p]<NUMREGS: register[wa[p]] <= wd[p] on rising edge.
- Write conflict (NWR=2, same valid address, both enabled): port 1 wins.
- Reads combinational: rd[i] = 0 if ra[i]==0 or ra[i]>=NUMREGS or state==INIT; else bypass value if applicable; else register[ra[i]].
- Bypass (BYPASS=1, RUN only): if any enabled write port targets ra[i] (nonzero, in range), rd[i] = that wd, port 1 prioritised; matches the value the register will hold next cycle.
- BYPASS=0: rd reflects register contents before the edge (read-old).
- Out-of-range addresses (E mode, ≥16): writes dropped silently, reads 0.

## Timing
- Reset values: rdy = 0; rd = 0 for all ports while in INIT.
- Clear sweep: rdy rises exactly NUMREGS-1 cycles after the first rising edge with reset_n high (31 cycles, 15 in E mode).
- Write latency: 1 cycle to storage; 0 cycles visible on rd with BYPASS=1.
- Read latency: 0 cycles (combinational from ra and state).
- reset_n asserted mid-sweep or in RUN: sweep restarts from x1 on the next edge; writes in that cycle dropped.
- reset_n low for multiple cycles: index held at 1, no clearing until release.

## Structure
- Package openhw_regfile_pkg: rf_state_t enum {RF_INIT, RF_RUN}; function numregs(E_SUPPORTED); constant REG_ADDR_W = 5.
- Sub-module openhw_regfile_clr_seq: INIT/RUN FSM and sweep counter; outputs clr_en, clr_addr, rdy. Top level muxes clr path into a single storage write port ahead of the functional ports.
- Bypass/priority logic is a generate loop per read port inside the top level.

## Test plan
- Release reset_n, hold we=0: rdy low for 31 cycles, high on 32nd; every register read back 0 (E mode: 15 cycles).
- RUN, NWR=2: port0 writes x5=0xAAAA, port1 writes x5=0x5555 same cycle -> next cycle rd(ra=x5) = 0x5555.
- BYPASS=1: write x7=0x1234 while ra[0]=x7 -> rd[0]=0x1234 same cycle; BYPASS=0 -> rd[0]=old value, 0x1234 next cycle.
- Write x0=0xFFFF, then read x0 on all ports -> 0; E mode write x20=0x1, read x20 -> 0, x4 unchanged.
- Write x3=0xDEAD, assert reset_n low one cycle mid-RUN -> rdy drops, rd=0 during sweep, x3 reads 0 after rdy returns.
- Assert we with x9=0x77 during INIT at cycle 3 -> write dropped; x9 reads 0 after rdy.
